// File: rtl/chip8_pkg.sv
// Shared keypad definitions: PS/2 set-2 prefix bytes, decoder state encoding,
// and the scancode-to-hex-key lookup.
package chip8_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] key;
  } key_lookup_t;

  function automatic key_lookup_t sc_to_key(input logic [7:0] sc);
    key_lookup_t r;
    r.hit = 1'b1;
    r.key = 4'h0;
    case (sc)
      8'h16: r.key = 4'h1;
      8'h1E: r.key = 4'h2;
      8'h26: r.key = 4'h3;
      8'h25: r.key = 4'hC;
      8'h15: r.key = 4'h4;
      8'h1D: r.key = 4'h5;
      8'h24: r.key = 4'h6;
      8'h2D: r.key = 4'hD;
      8'h1C: r.key = 4'h7;
      8'h1B: r.key = 4'h8;
      8'h23: r.key = 4'h9;
      8'h2B: r.key = 4'hE;
      8'h1A: r.key = 4'hA;
      8'h22: r.key = 4'h0;
      8'h21: r.key = 4'hB;
      8'h2A: r.key = 4'hF;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_event_fifo.sv
// First-word-fall-through key-event FIFO with sticky overflow flag.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module keypad_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             empty_c, full_c, do_pop_c, do_push_c;

  always_comb begin
    empty_c   = (cnt_q == '0);
    full_c    = (cnt_q == CW'(DEPTH));
    do_pop_c  = pop_i & ~empty_c;
    do_push_c = push_i & (~full_c | do_pop_c);
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_push_c) wr_d = wr_q + AW'(1);
      if (do_pop_c)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push_c) - CW'(do_pop_c);
      if (push_i & ~do_push_c) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Storage needs no reset: a slot is only visible after it has been written.
  always_ff @(posedge clk) begin
    if (do_push_c & ~clear_i) mem_q[wr_q] <= data_i;
  end

  assign valid_o    = ~empty_c;
  assign data_o     = empty_c ? '0 : mem_q[rd_q];
  assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_matrix.sv
// PS/2 set-2 scancode decoder driving a held-key matrix and an optional
// key-event FIFO (enabled by defining KEYPAD_EVENT_FIFO_EN).
module keypad_matrix
  import chip8_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned KW         = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                res,
  input  logic                kb_ready,
  input  logic [7:0]          kb_data,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_matrix,
  output logic                evt_valid,
  output logic                evt_pressed,
  output logic [KW-1:0]       evt_key,
  input  logic                evt_pop,
  output logic                overflow
);

  logic          sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0]    warm_q;
  logic          strobe_c;
  kbd_state_e    state_q, state_d;
  key_lookup_t   lk_c;
  logic          prefix_c, in_range_c, make_c, brk_c, held_c, chg_c, push_c;
  logic [KW-1:0] key_idx_c;
  logic [NUM_KEYS-1:0] onehot_c, matrix_q, matrix_d;

  // Edge detect only arms once kb_ready has been seen low after reset, so a
  // byte still held at reset release is dropped.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      warm_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= kb_ready;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      warm_q  <= {warm_q[0], 1'b1};
      armed_q <= armed_q | (warm_q[1] & ~sync2_q);
    end
  end

  assign strobe_c = sync2_q & ~prev_q & armed_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else if (strobe_c) begin
      case (state_q)
        ST_IDLE: begin
          if (kb_data == SC_BREAK)    state_d = ST_BRK;
          else if (kb_data == SC_EXT) state_d = ST_EXT;
        end
        ST_BRK:     if (!prefix_c) state_d = ST_IDLE;
        ST_EXT:     state_d = (kb_data == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        ST_EXT_BRK: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  assign lk_c       = sc_to_key(kb_data);
  assign prefix_c   = (kb_data == SC_BREAK) || (kb_data == SC_EXT);
  assign in_range_c = 32'(lk_c.key) < NUM_KEYS;

  always_comb begin
    make_c = 1'b0;
    brk_c  = 1'b0;
    if (strobe_c && !prefix_c && lk_c.hit && in_range_c) begin
      make_c = (state_q == ST_IDLE);
      brk_c  = (state_q == ST_BRK);
    end
  end

  // Typematic makes and breaks of released keys leave the matrix untouched.
  always_comb begin
    key_idx_c = KW'(lk_c.key);
    onehot_c  = NUM_KEYS'(1) << key_idx_c;
    held_c    = |(matrix_q & onehot_c);
    chg_c     = (make_c & ~held_c) | (brk_c & held_c);
    push_c    = chg_c & ~clear;
    matrix_d  = matrix_q;
    if (clear)      matrix_d = '0;
    else if (chg_c) matrix_d = matrix_q ^ onehot_c;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) matrix_q <= '0;
    else     matrix_q <= matrix_d;
  end

  assign key_matrix = matrix_q;

`ifdef KEYPAD_EVENT_FIFO_EN
  logic [KW:0] head_c;

  keypad_event_fifo #(
    .WIDTH(KW + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .res       (res),
    .clear_i   (clear),
    .push_i    (push_c),
    .data_i    ({make_c, key_idx_c}),
    .pop_i     (evt_pop),
    .valid_o   (evt_valid),
    .data_o    (head_c),
    .overflow_o(overflow)
  );

  assign evt_pressed = head_c[KW];
  assign evt_key     = head_c[KW-1:0];
`else
  logic unused_evt;
  assign unused_evt  = ^{evt_pop, push_c};
  assign evt_valid   = 1'b0;
  assign evt_pressed = 1'b0;
  assign evt_key     = '0;
  assign overflow    = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_matrix.sv
// Directed scoreboard bench for keypad_matrix: a 16-key and an 8-key instance
// share the PS/2 stimulus; event checks adapt to KEYPAD_EVENT_FIFO_EN.
module tb_keypad_matrix;

`ifdef KEYPAD_EVENT_FIFO_EN
  localparam bit FIFO_ON = 1'b1;
`else
  localparam bit FIFO_ON = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] m16;
    logic [7:0]  m8;
  } exp_t;

  logic        clk = 1'b0;
  logic        res, kb_ready, clear, evt_pop;
  logic [7:0]  kb_data;
  logic [15:0] key_matrix;
  logic        evt_valid, evt_pressed, overflow;
  logic [3:0]  evt_key;
  logic [7:0]  km8;
  logic        unused8_valid, unused8_pressed, unused8_ovf;
  logic [2:0]  unused8_key;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] last16 = '0;
  exp_t        sb[$];
  logic [4:0]  evq[$];

  keypad_matrix #(.NUM_KEYS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .res(res), .kb_ready(kb_ready), .kb_data(kb_data), .clear(clear),
    .key_matrix(key_matrix), .evt_valid(evt_valid), .evt_pressed(evt_pressed),
    .evt_key(evt_key), .evt_pop(evt_pop), .overflow(overflow)
  );

  keypad_matrix #(.NUM_KEYS(8), .FIFO_DEPTH(4)) dut8 (
    .clk(clk), .res(res), .kb_ready(kb_ready), .kb_data(kb_data), .clear(clear),
    .key_matrix(km8), .evt_valid(unused8_valid), .evt_pressed(unused8_pressed),
    .evt_key(unused8_key), .evt_pop(evt_pop), .overflow(unused8_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_evt(input logic p, input logic [3:0] k);
    evq.push_back({p, k});
  endtask

  // Drive one byte; the matrix must hold for two edges and update on the third.
  task automatic send_byte(input logic [7:0] b, input logic [15:0] m16,
                           input logic [7:0] m8, input bit pop_s);
    exp_t cur;
    sb.push_back({m16, m8});
    @(negedge clk);
    kb_data  = b;
    kb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_update", 32'(key_matrix), 32'(last16));
    if (pop_s) evt_pop = 1'b1;
    @(posedge clk);
    #1;
    evt_pop = 1'b0;
    cur = sb.pop_front();
    check("matrix16", 32'(key_matrix), 32'(cur.m16));
    check("matrix8", 32'(km8), 32'(cur.m8));
    last16 = cur.m16;
    @(negedge clk);
    kb_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
`ifdef KEYPAD_EVENT_FIFO_EN
    logic [4:0] e;
    while (evq.size() > 0) begin
      e = evq.pop_front();
      check("evt_valid", 32'(evt_valid), 32'(1));
      check("evt_pressed", 32'(evt_pressed), 32'(e[4]));
      check("evt_key", 32'(evt_key), 32'(e[3:0]));
      @(negedge clk);
      evt_pop = 1'b1;
      @(negedge clk);
      evt_pop = 1'b0;
    end
`else
    evq.delete();
`endif
    check("evt_empty", 32'(evt_valid), 32'(0));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    last16 = '0;
  endtask

  initial begin
    res = 1'b1; kb_ready = 1'b0; kb_data = 8'h00; clear = 1'b0; evt_pop = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_matrix", 32'(key_matrix), 32'(0));
    check("rst_valid", 32'(evt_valid), 32'(0));
    check("rst_pressed", 32'(evt_pressed), 32'(0));
    check("rst_key", 32'(evt_key), 32'(0));
    check("rst_ovf", 32'(overflow), 32'(0));
    res = 1'b0;
    repeat (5) @(negedge clk);

    // make / break of key 1
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b0);
    send_byte(8'hF0, 16'h0002, 8'h02, 1'b0);
    exp_evt(1'b0, 4'h1); send_byte(8'h16, 16'h0000, 8'h00, 1'b0);
    drain();

    // typematic repeats of key A: one event only; key A absent on the 8-key part
    exp_evt(1'b1, 4'hA);
    repeat (3) send_byte(8'h1A, 16'h0400, 8'h00, 1'b0);
    drain();
    exp_evt(1'b0, 4'hA);
    send_byte(8'hF0, 16'h0400, 8'h00, 1'b0);
    send_byte(8'h1A, 16'h0000, 8'h00, 1'b0);
    drain();

    // extended make and break are discarded
    send_byte(8'hE0, 16'h0000, 8'h00, 1'b0);
    send_byte(8'h75, 16'h0000, 8'h00, 1'b0);
    send_byte(8'hE0, 16'h0000, 8'h00, 1'b0);
    send_byte(8'hF0, 16'h0000, 8'h00, 1'b0);
    send_byte(8'h75, 16'h0000, 8'h00, 1'b0);
    drain();

    // decoder back in IDLE; prefixes inside BRK are ignored; break of released key
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b0);
    send_byte(8'hF0, 16'h0002, 8'h02, 1'b0);
    send_byte(8'hE0, 16'h0002, 8'h02, 1'b0);
    exp_evt(1'b0, 4'h1); send_byte(8'h16, 16'h0000, 8'h00, 1'b0);
    send_byte(8'hF0, 16'h0000, 8'h00, 1'b0);
    send_byte(8'h16, 16'h0000, 8'h00, 1'b0);
    drain();

    // key F out of range on 8-key part, key 7 in range
    exp_evt(1'b1, 4'hF); send_byte(8'h2A, 16'h8000, 8'h00, 1'b0);
    exp_evt(1'b1, 4'h7); send_byte(8'h1C, 16'h8080, 8'h80, 1'b0);
    drain();
    pulse_clear();
    check("clr_matrix16", 32'(key_matrix), 32'(0));
    check("clr_matrix8", 32'(km8), 32'(0));

    // five makes with no pops: four queued, fifth dropped
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b0);
    exp_evt(1'b1, 4'h2); send_byte(8'h1E, 16'h0006, 8'h06, 1'b0);
    exp_evt(1'b1, 4'h3); send_byte(8'h26, 16'h000E, 8'h0E, 1'b0);
    exp_evt(1'b1, 4'hC); send_byte(8'h25, 16'h100E, 8'h0E, 1'b0);
    send_byte(8'h15, 16'h101E, 8'h1E, 1'b0);
    check("ovf_set", 32'(overflow), 32'(FIFO_ON));
    drain();
    check("ovf_sticky", 32'(overflow), 32'(FIFO_ON));
    pulse_clear();
    check("ovf_clear", 32'(overflow), 32'(0));
    check("clr2_matrix", 32'(key_matrix), 32'(0));

    // push with coincident pop while full is accepted
    send_byte(8'h1D, 16'h0020, 8'h20, 1'b0);
    exp_evt(1'b1, 4'h6); send_byte(8'h24, 16'h0060, 8'h60, 1'b0);
    exp_evt(1'b1, 4'hD); send_byte(8'h2D, 16'h2060, 8'h60, 1'b0);
    exp_evt(1'b1, 4'h7); send_byte(8'h1C, 16'h20E0, 8'hE0, 1'b0);
    exp_evt(1'b1, 4'h8); send_byte(8'h1B, 16'h21E0, 8'hE0, 1'b1);
    check("full_pushpop_ovf", 32'(overflow), 32'(0));
    drain();
    pulse_clear();

    // push with pop while empty: event kept, visible next cycle
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b1);
    drain();

    // clear coincident with a byte strobe wins, and returns decoder from BRK
    send_byte(8'hF0, 16'h0002, 8'h02, 1'b0);
    @(negedge clk);
    kb_data  = 8'h16;
    kb_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    last16 = '0;
    check("clr_strobe_matrix", 32'(key_matrix), 32'(0));
    check("clr_strobe_valid", 32'(evt_valid), 32'(0));
    @(negedge clk);
    kb_ready = 1'b0;
    repeat (3) @(negedge clk);
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b0);
    drain();
    pulse_clear();

    // asynchronous reset after a break prefix
    exp_evt(1'b1, 4'h2); send_byte(8'h1E, 16'h0004, 8'h04, 1'b0);
    send_byte(8'hF0, 16'h0004, 8'h04, 1'b0);
    @(negedge clk);
    res = 1'b1;
    #1;
    check("ares_matrix16", 32'(key_matrix), 32'(0));
    check("ares_matrix8", 32'(km8), 32'(0));
    check("ares_valid", 32'(evt_valid), 32'(0));
    check("ares_key", 32'(evt_key), 32'(0));
    check("ares_pressed", 32'(evt_pressed), 32'(0));
    check("ares_ovf", 32'(overflow), 32'(0));
    evq.delete();
    repeat (2) @(negedge clk);
    res = 1'b0;
    last16 = '0;
    repeat (5) @(negedge clk);
    exp_evt(1'b1, 4'h1); send_byte(8'h16, 16'h0002, 8'h02, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
